// File: rtl/ip_encoder.sv
// Transmit-side IPv4 header builder: latches header fields on start, computes the
// header checksum over three sum cycles plus a fold, then streams three 64-bit words.
module ip_encoder #(
    parameter bit AUTO_CHECKSUM = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  version,
    input  logic [3:0]  headerLength,
    input  logic [7:0]  typeOfService,
    input  logic [15:0] totalLength,
    input  logic [15:0] identification,
    input  logic [2:0]  flags,
    input  logic [12:0] fragmentOffset,
    input  logic [7:0]  timeToLive,
    input  logic [7:0]  protocol,
    input  logic [15:0] headerChecksum,
    input  logic [31:0] srcIPAddress,
    input  logic [31:0] destIPAddress,
    output logic [63:0] dataOut,
    output logic        dataValid,
    input  logic        dataReady,
    output logic [6:0]  counterOut,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        SUM2,
        SUM3,
        SUM4,
        FOLD,
        SEND2,
        SEND3,
        SEND4
    } state_t;

    state_t      state;
    logic [63:0] w2Reg;
    logic [31:0] srcReg;
    logic [31:0] dstReg;
    logic [7:0]  ttlReg;
    logic [7:0]  protoReg;
    logic [15:0] hcReg;
    logic [19:0] acc;
    logic [15:0] checksum;
    logic [16:0] s1;
    logic [15:0] s2;

    function automatic logic [19:0] hsum4(input logic [63:0] w);
        return {4'b0, w[15:0]} + {4'b0, w[31:16]} + {4'b0, w[47:32]} + {4'b0, w[63:48]};
    endfunction

    // Two-step end-around-carry fold of the 20-bit accumulator.
    always_comb begin
        s1 = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
        s2 = s1[15:0] + {15'b0, s1[16]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            w2Reg      <= '0;
            srcReg     <= '0;
            dstReg     <= '0;
            ttlReg     <= '0;
            protoReg   <= '0;
            hcReg      <= '0;
            acc        <= '0;
            checksum   <= '0;
            dataOut    <= '0;
            dataValid  <= 1'b0;
            counterOut <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w2Reg    <= {fragmentOffset, flags, identification, totalLength,
                                     typeOfService, headerLength, version};
                        srcReg   <= srcIPAddress;
                        dstReg   <= destIPAddress;
                        ttlReg   <= timeToLive;
                        protoReg <= protocol;
                        hcReg    <= headerChecksum;
                        acc      <= '0;
                        busy     <= 1'b1;
                        state    <= SUM2;
                    end
                end
                SUM2: begin
                    acc   <= acc + hsum4(w2Reg);
                    state <= SUM3;
                end
                SUM3: begin
                    // Checksum field counts as zero while summing.
                    acc   <= acc + hsum4({srcReg, 16'h0000, protoReg, ttlReg});
                    state <= SUM4;
                end
                SUM4: begin
                    acc   <= acc + {4'b0, dstReg[15:0]} + {4'b0, dstReg[31:16]};
                    state <= FOLD;
                end
                FOLD: begin
                    checksum   <= AUTO_CHECKSUM ? ~s2 : hcReg;
                    dataOut    <= w2Reg;
                    dataValid  <= 1'b1;
                    counterOut <= 7'd2;
                    state      <= SEND2;
                end
                SEND2: begin
                    if (dataValid && dataReady) begin
                        dataOut    <= {srcReg, checksum, protoReg, ttlReg};
                        counterOut <= 7'd3;
                        state      <= SEND3;
                    end
                end
                SEND3: begin
                    if (dataValid && dataReady) begin
                        dataOut    <= {32'h0, dstReg};
                        counterOut <= 7'd4;
                        state      <= SEND4;
                    end
                end
                SEND4: begin
                    if (dataValid && dataReady) begin
                        dataOut    <= '0;
                        dataValid  <= 1'b0;
                        counterOut <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ip_encoder.md
# ip_encoder

Transmit-side IPv4 header builder. It latches a set of header fields on a start pulse and computes the header checksum over three cycles plus one fold cycle. It then emits the header as three 64-bit words on a valid/ready stream, tagged with word indices 2, 3 and 4. Bit packing per word is identical to the receive-side IP header decoder, so output looped back through the decoder reproduces the input fields.

## Interface
Parameters:
- AUTO_CHECKSUM, 1, 1: checksum computed internally; 0: headerChecksum input passed through unmodified.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; accepted only when busy=0.
- version  input  4  IP version.
- headerLength  input  4  IHL.
- typeOfService  input  8  TOS.
- totalLength  input  16  total length.
- identification  input  16  ID.
- flags  input  3  flags.
- fragmentOffset  input  13  fragment offset.
- timeToLive  input  8  TTL.
- protocol  input  8  protocol.
- headerChecksum  input  16  used only when AUTO_CHECKSUM=0.
- srcIPAddress  input  32  source address.
- destIPAddress  input  32  destination address.
- dataOut  output  64  header word.
- dataValid  output  1  dataOut/counterOut valid.
- dataReady  input  1  downstream accepts word when high with dataValid.
- counterOut  output  7  word index: 2, 3 or 4 while valid, else 0.
- busy  output  1  high from accepted start until final handshake.
- done  output  1  one-cycle pulse after word-4 handshake.

## Operation
- Word packing:
  - W2 = {fragmentOffset[63:51], flags[50:48], identification[47:32], totalLength[31:16], typeOfService[15:8], headerLength[7:4], version[3:0]}.
  - W3 = {srcIPAddress[63:32], checksum[31:16], protocol[15:8], timeToLive[7:0]}.
  - W4 = {32'h0, destIPAddress[31:0]}.
- All field inputs are latched on the accepting start edge. Later input changes have no effect until the next start.
- Checksum (AUTO_CHECKSUM=1): one's-complement sum of the ten 16-bit halfwords W2[63:0], W3[63:0] with the checksum field as 0, and W4[31:0].
  - 20-bit accumulator; no overflow possible.
  - Fold: s1 = acc[15:0] + acc[19:16] (17 bits).
  - s2 = s1[15:0] + s1[16].
  - checksum = ~s2[15:0].
- FSM states:
  - IDLE: start=1 latches fields, clears acc, goes to SUM2.
  - SUM2: acc += four halfwords of W2; goes to SUM3.
  - SUM3: acc += four halfwords of W3 (checksum field zeroed); goes to SUM4.
  - SUM4: acc += W4[15:0] + W4[31:16]; goes to FOLD.
  - FOLD: checksum register loaded; goes to SEND2.
  - SEND2, SEND3, SEND4: hold word; advance on dataValid && dataReady.
  - SEND4 handshake returns to IDLE.
- With AUTO_CHECKSUM=0, the SUM/FOLD states still execute (fixed latency), and the checksum register loads the latched headerChecksum.
- start while busy=1 is ignored; no queuing.
- Reset, including mid-operation: the FSM goes to IDLE and any partially sent header is abandoned.

## Timing
- Reset values:
  - dataOut=0, dataValid=0, counterOut=0, busy=0, done=0.
  - Accumulator, checksum and latched fields all 0.
- All outputs are registered.
- start sampled high in IDLE at cycle 0 → busy=1 from cycle 1. SUM2/SUM3/SUM4/FOLD occupy cycles 1–4. dataValid=1 with W2 and counterOut=2 in cycle 5 at the earliest.
- With dataReady held high, words appear in cycles 5, 6, 7. In cycle 8: done=1, busy=0, dataValid=0.
- dataValid, dataOut and counterOut stay stable while dataReady=0. No bubble is inserted between words when dataReady=1.
- dataOut=0 and counterOut=0 whenever dataValid=0.
- start in the done cycle (state IDLE) is accepted; the next W2 is valid 5 cycles later.
- done is never asserted during or immediately after reset.

## Test plan
- Fields ver=4, IHL=5, TOS=0, totLen=0x0073, ID=0, flags=3'b010, frag=0, TTL=0x40, proto=0x11, src=0xC0A80001, dst=0xC0A800C7, dataReady=1 → W2=0x0002_0000_0073_0054 (cycle 5), W3=0xC0A80001_6BDD_1140 (cycle 6), W4=0x00000000_C0A800C7 (cycle 7), done in cycle 8.
- Same header, dataReady low in cycles 5–9 and high from cycle 10 → W2 held for cycles 5–10, W3 in cycle 11, W4 in cycle 12. counterOut tracks 2, 3, 4.
- All fields 0xFF… (max halfwords) → exercises fold carry. Checksum equals a reference model; acc never exceeds 20 bits.
- AUTO_CHECKSUM=0, headerChecksum=0xBEEF → W3[31:16]=0xBEEF; timing identical to scenario 1.
- start pulsed in cycles 2 and 6 of an active transfer → both ignored; exactly one header is emitted. A back-to-back start in the done cycle yields a second W2 five cycles later.
- rst asserted in cycle 6 (W3 pending) → next cycle all outputs 0 and busy=0. A fresh start then produces the full header from W2.
